// File: rtl/l2_pkg.sv
// Shared L2 miss-path constants, state encoding and tag-width helper.
package l2_pkg;

  localparam int LINE_W   = 512;
  localparam int INDEX_W  = 8;
  localparam int WAY_W    = 2;
  localparam int OFFSET_W = 6;

  function automatic int tag_w(input int addr_w);
    return addr_w - INDEX_W - OFFSET_W;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_REFILL  = 3'd4,
    ST_DONE    = 3'd5
  } l2_miss_state_t;

endpackage

// File: rtl/l2_watchdog.sv
// Loadable up-counter with clear and enable; tc flags the last allowed wait cycle.
module l2_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/l2_miss_handler.sv
// Single-outstanding L2 miss engine: optional victim write-back, line fetch, refill strobe.
//   state   | meaning
//   IDLE    | waiting for miss_req
//   WB_REQ  | writing dirty victim to memory
//   RD_REQ  | requesting missing line
//   RD_WAIT | waiting for read data
//   REFILL  | one-cycle write into data array
//   DONE    | one-cycle completion pulse
module l2_miss_handler
  import l2_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       miss_req,
  input  logic [INDEX_W-1:0]         miss_index,
  input  logic [tag_w(ADDR_W)-1:0]   miss_tag,
  input  logic [WAY_W-1:0]           miss_way,
  input  logic                       victim_dirty,
  input  logic [tag_w(ADDR_W)-1:0]   victim_tag,
  input  logic [LINE_W-1:0]          victim_data,
  output logic                       miss_busy,
  output logic                       miss_done,
  output logic                       miss_err,
  output logic                       refill,
  output logic [INDEX_W-1:0]         refill_index,
  output logic [WAY_W-1:0]           refill_way,
  output logic [LINE_W-1:0]          refill_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic                       mem_rvalid,
  input  logic [LINE_W-1:0]          mem_rdata
);

  localparam int TAG_W = tag_w(ADDR_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  l2_miss_state_t      state_q, state_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;
  logic [LINE_W-1:0]   vdata_q, vdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                wd_en, wd_clr, wd_tc;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    tag_d     = tag_q;
    way_d     = way_q;
    vtag_d    = vtag_q;
    vdata_d   = vdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    refill    = 1'b0;
    miss_done = 1'b0;
    wd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          index_d = miss_index;
          tag_d   = miss_tag;
          way_d   = miss_way;
          vtag_d  = victim_tag;
          vdata_d = victim_data;
          err_d   = 1'b0;
          state_d = victim_dirty ? ST_WB_REQ : ST_RD_REQ;
        end
      end
      ST_WB_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {vtag_q, index_q, {OFFSET_W{1'b0}}};
        wd_en    = 1'b1;
        if (mem_ack) state_d = ST_RD_REQ;
        else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, index_q, {OFFSET_W{1'b0}}};
        wd_en    = 1'b1;
        if (mem_ack) state_d = ST_RD_WAIT;
        else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_WAIT: begin
        wd_en = 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_REFILL;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_REFILL: begin
        refill  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        miss_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wd_clr = (state_d != state_q);

  l2_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_watchdog (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (wd_clr),
    .en       (wd_en),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .tc       (wd_tc)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
      vdata_q <= vdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign miss_busy    = (state_q != ST_IDLE);
  assign miss_err     = err_q;
  assign refill_index = index_q;
  assign refill_way   = way_q;
  assign refill_data  = rdata_q;
  assign mem_wdata    = vdata_q;

endmodule

// File: tb/tb_l2_miss_handler.sv
// Directed bench for l2_miss_handler with hand-computed addresses and timing.
module tb_l2_miss_handler;

  localparam int ADDR_W = 32;
  localparam int TW     = 18;
  localparam int TO     = 16;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           miss_req = 1'b0;
  logic [7:0]     miss_index = '0;
  logic [TW-1:0]  miss_tag = '0;
  logic [1:0]     miss_way = '0;
  logic           victim_dirty = 1'b0;
  logic [TW-1:0]  victim_tag = '0;
  logic [511:0]   victim_data = '0;
  logic           miss_busy, miss_done, miss_err, refill;
  logic [7:0]     refill_index;
  logic [1:0]     refill_way;
  logic [511:0]   refill_data;
  logic           mem_req, mem_we;
  logic [31:0]    mem_addr;
  logic [511:0]   mem_wdata;
  logic           mem_ack = 1'b0;
  logic           mem_rvalid = 1'b0;
  logic [511:0]   mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [511:0] pat_a5, pat_5a, pat_3c, pat_ff;

  l2_miss_handler #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .miss_req(miss_req), .miss_index(miss_index), .miss_tag(miss_tag),
    .miss_way(miss_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_data(victim_data),
    .miss_busy(miss_busy), .miss_done(miss_done), .miss_err(miss_err),
    .refill(refill), .refill_index(refill_index), .refill_way(refill_way),
    .refill_data(refill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [7:0] idx, input logic [TW-1:0] tg, input logic [1:0] w,
                            input logic dirty, input logic [TW-1:0] vt, input logic [511:0] vd);
    miss_req     = 1'b1;
    miss_index   = idx;
    miss_tag     = tg;
    miss_way     = w;
    victim_dirty = dirty;
    victim_tag   = vt;
    victim_data  = vd;
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_3c = {64{8'h3C}};
    pat_ff = {64{8'hFF}};

    // reset state
    #2;
    check("rst_busy", miss_busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", refill_data, 0);
    check("rst_refill", refill, 0);
    check("rst_err", miss_err, 0);
    #10 nrst = 1'b1;
    tick();

    // clean miss, minimum latency
    start_miss(8'h12, 18'h00ABC, 2'd2, 1'b0, 18'h0, '0);
    tick();                                        // N accepted, now RD_REQ
    miss_req = 1'b0;
    check("clean_req", mem_req, 1);
    check("clean_we", mem_we, 0);
    check("clean_addr", mem_addr, 32'h02AF0480);
    check("clean_busy", miss_busy, 1);
    mem_ack = 1'b1;
    tick();                                        // RD_WAIT
    mem_ack = 1'b0;
    check("clean_req_drop", mem_req, 0);
    check("clean_no_refill_wait", refill, 0);
    mem_rvalid = 1'b1; mem_rdata = pat_a5;
    tick();                                        // REFILL, N+3
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("clean_refill", refill, 1);
    check("clean_ridx", refill_index, 8'h12);
    check("clean_rway", refill_way, 2'd2);
    check("clean_rdata", refill_data, pat_a5);
    check("clean_done_early", miss_done, 0);
    tick();                                        // DONE, N+4
    check("clean_done", miss_done, 1);
    check("clean_refill_once", refill, 0);
    tick();
    check("clean_idle", miss_busy, 0);
    check("clean_done_once", miss_done, 0);

    // dirty miss with write-back backpressure; victim_data changes after acceptance
    start_miss(8'h12, 18'h00ABC, 2'd1, 1'b1, 18'h1, pat_5a);
    tick();                                        // WB_REQ
    miss_req = 1'b0;
    victim_data = pat_ff;
    for (int i = 0; i < 7; i++) begin
      check("bp_req", mem_req, 1);
      check("bp_we", mem_we, 1);
      check("bp_addr", mem_addr, 32'h00004480);
      check("bp_wdata", mem_wdata, pat_5a);
      check("bp_no_refill", refill, 0);
      tick();
    end
    check("dirty_wb_addr", mem_addr, 32'h00004480);
    mem_ack = 1'b1;
    tick();                                        // RD_REQ
    check("dirty_rd_we", mem_we, 0);
    check("dirty_rd_addr", mem_addr, 32'h02AF0480);
    check("dirty_rd_req", mem_req, 1);
    tick();                                        // RD_WAIT
    mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = pat_3c;
    tick();                                        // REFILL
    mem_rvalid = 1'b0;
    check("dirty_refill", refill, 1);
    check("dirty_rway", refill_way, 2'd1);
    check("dirty_rdata", refill_data, pat_3c);
    tick();
    check("dirty_done", miss_done, 1);
    check("dirty_err", miss_err, 0);
    tick();

    // timeout in RD_WAIT
    start_miss(8'h34, 18'h00001, 2'd3, 1'b0, 18'h0, '0);
    tick();                                        // RD_REQ
    miss_req = 1'b0;
    mem_ack = 1'b1;
    tick();                                        // RD_WAIT, counter 0
    mem_ack = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_wait_done", miss_done, 0);
      check("to_wait_refill", refill, 0);
      check("to_wait_err", miss_err, 0);
    end
    tick();                                        // DONE after TIMEOUT cycles
    check("to_done", miss_done, 1);
    check("to_err", miss_err, 1);
    check("to_no_refill", refill, 0);
    check("to_req", mem_req, 0);
    tick();
    check("to_err_sticky", miss_err, 1);
    check("to_idle", miss_busy, 0);

    // next miss clears error; miss_req while busy is ignored
    start_miss(8'h56, 18'h00002, 2'd0, 1'b0, 18'h0, '0);
    tick();                                        // RD_REQ
    check("clr_err", miss_err, 0);
    check("clr_addr", mem_addr, 32'h00009580);
    miss_index = 8'h77; miss_way = 2'd3;           // held request with new fields
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = pat_a5;
    tick();                                        // REFILL
    mem_rvalid = 1'b0;
    miss_req = 1'b0;
    check("busy_ign_idx", refill_index, 8'h56);
    check("busy_ign_way", refill_way, 2'd0);
    check("busy_refill", refill, 1);
    tick();
    check("busy_done", miss_done, 1);
    tick();

    // spurious rvalid in IDLE
    mem_rvalid = 1'b1; mem_rdata = pat_ff;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_busy", miss_busy, 0);
      check("spur_refill", refill, 0);
    end
    mem_rvalid = 1'b0;
    check("spur_rdata", refill_data, pat_a5);

    // asynchronous reset in RD_WAIT
    start_miss(8'h12, 18'h00ABC, 2'd2, 1'b0, 18'h0, '0);
    tick();
    miss_req = 1'b0;
    mem_ack = 1'b1;
    tick();                                        // RD_WAIT
    mem_ack = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("ar_busy", miss_busy, 0);
    check("ar_req", mem_req, 0);
    check("ar_refill", refill, 0);
    check("ar_rdata", refill_data, 0);
    check("ar_addr", mem_addr, 0);
    #3 nrst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = pat_3c;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_refill", refill, 0);
      check("ar_no_done", miss_done, 0);
    end
    mem_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
